// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one multi-cycle logic/arithmetic unit
// between two requesters; holds unit inputs stable, returns the result.
module alu_share_ctrl #(
    parameter int WIDTH       = 32,
    parameter int OP_W        = 4,
    parameter int EXEC_CYCLES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy
);

    localparam int CW = $clog2(EXEC_CYCLES + 1);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          prio;
    logic          owner;
    logic [CW-1:0] count;
    logic          accept;
    logic          done;

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                // prio==0 favours requester 0 on a tie
                req0_ready = req0_valid & (~req1_valid | ~prio);
                req1_ready = req1_valid & (~req0_valid | prio);
                if (req0_ready | req1_ready)
                    state_nxt = EXEC;
            end
            EXEC: begin
                if (count == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = req0_ready | req1_ready;
    assign busy   = (state == EXEC);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            prio        <= 1'b0;
            owner       <= 1'b0;
            count       <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp_data   <= '0;
        end else begin
            state       <= state_nxt;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            if (accept) begin
                alu_a  <= req1_ready ? req1_a  : req0_a;
                alu_b  <= req1_ready ? req1_b  : req0_b;
                alu_op <= req1_ready ? req1_op : req0_op;
                owner  <= req1_ready;
                prio   <= ~req1_ready;
                count  <= CW'(EXEC_CYCLES - 1);
            end else if (busy && !done) begin
                count <= count - 1'b1;
            end
            if (done) begin
                resp_data   <= alu_result;
                resp0_valid <= ~owner;
                resp1_valid <= owner;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: EXEC_CYCLES=2 and EXEC_CYCLES=1 instances.
module tb_alu_share_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;

    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [31:0] req0_a = '0;
    logic [31:0] req0_b = '0;
    logic [3:0]  req0_op = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [31:0] req1_a = '0;
    logic [31:0] req1_b = '0;
    logic [3:0]  req1_op = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        resp0_valid;
    logic        resp1_valid;
    logic [31:0] resp_data;
    logic        busy;

    logic        use_stub = 1'b0;
    logic [31:0] stub_val = '0;

    logic        q0_valid = 1'b0;
    logic        q0_ready;
    logic [31:0] q0_a = 32'h0000_FF00;
    logic [31:0] q0_b = 32'h0000_00FF;
    logic        q1_valid = 1'b0;
    logic        q1_ready;
    logic [31:0] q1_a = 32'h8000_0000;
    logic [31:0] q1_b = 32'h0000_0001;
    logic [31:0] x_alu_a;
    logic [31:0] x_alu_b;
    logic [3:0]  x_alu_op;
    logic [31:0] x_result;
    logic        x_resp0;
    logic        x_resp1;
    logic [31:0] x_data;
    logic        x_busy;

    int compared = 0;
    int mismatched = 0;

    always #5 Clk = ~Clk;

    // Stub unit computes A|B unless a test forces a per-cycle value
    assign alu_result = use_stub ? stub_val : (alu_a | alu_b);
    assign x_result   = x_alu_a | x_alu_b;

    alu_share_ctrl #(.WIDTH(32), .OP_W(4), .EXEC_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_data(resp_data), .busy(busy)
    );

    alu_share_ctrl #(.WIDTH(32), .OP_W(4), .EXEC_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset),
        .req0_valid(q0_valid), .req0_ready(q0_ready),
        .req0_a(q0_a), .req0_b(q0_b), .req0_op(4'h1),
        .req1_valid(q1_valid), .req1_ready(q1_ready),
        .req1_a(q1_a), .req1_b(q1_b), .req1_op(4'h2),
        .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_op(x_alu_op),
        .alu_result(x_result),
        .resp0_valid(x_resp0), .resp1_valid(x_resp1),
        .resp_data(x_data), .busy(x_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [31:0] a0 [2] = '{32'h0000_00F0, 32'h0000_1100};
    logic [31:0] b0 [2] = '{32'h0000_000F, 32'h0000_0011};
    logic [31:0] a1 [2] = '{32'h00F0_0000, 32'hA000_0000};
    logic [31:0] b1 [2] = '{32'h0F00_0000, 32'h0000_000A};
    logic [31:0] e0 [2] = '{32'h0000_00FF, 32'h0000_1111};
    logic [31:0] e1 [2] = '{32'h0FF0_0000, 32'hA000_000A};
    logic [31:0] xe [2] = '{32'h0000_FFFF, 32'h8000_0001};

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_resp", {30'd0, resp1_valid, resp0_valid}, 0);
        chk("rst_data", resp_data, 0);
        Reset = 1'b0;

        // 1: single req0 operation
        req0_valid = 1'b1; req0_a = 32'h0F0F; req0_b = 32'h00FF; req0_op = 4'h3;
        #1;
        chk("t1_ready", {30'd0, req1_ready, req0_ready}, 32'h1);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_ready_exec", 32'(req0_ready), 0);
        chk("t1_alu_a", alu_a, 32'h0F0F);
        chk("t1_alu_b", alu_b, 32'h00FF);
        chk("t1_alu_op", 32'(alu_op), 3);
        tick();
        chk("t1_early_resp", {30'd0, resp1_valid, resp0_valid}, 0);
        tick();
        chk("t1_resp", {30'd0, resp1_valid, resp0_valid}, 32'h1);
        chk("t1_data", resp_data, 32'h0000_0FFF);
        chk("t1_idle", 32'(busy), 0);
        tick();
        chk("t1_pulse_end", {30'd0, resp1_valid, resp0_valid}, 0);
        chk("t1_data_hold", resp_data, 32'h0000_0FFF);

        // 2: contention after a fresh reset, grants alternate from 0
        Reset = 1'b1; tick(); Reset = 1'b0;
        req0_valid = 1'b1; req0_a = a0[0]; req0_b = b0[0]; req0_op = 4'h4;
        req1_valid = 1'b1; req1_a = a1[0]; req1_b = b1[0]; req1_op = 4'h5;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_ready%0d", i), {30'd0, req1_ready, req0_ready},
                (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i > 0) begin
                chk($sformatf("t2_resp%0d", i - 1),
                    {30'd0, resp1_valid, resp0_valid},
                    (i % 2 == 1) ? 32'h1 : 32'h2);
                chk($sformatf("t2_data%0d", i - 1), resp_data,
                    (i % 2 == 1) ? e0[(i-1)/2] : e1[(i-1)/2]);
            end
            tick();
            if (i % 2 == 0) begin
                if (i == 0) begin req0_a = a0[1]; req0_b = b0[1]; end
                else req0_valid = 1'b0;
            end else begin
                if (i == 1) begin req1_a = a1[1]; req1_b = b1[1]; end
                else req1_valid = 1'b0;
            end
            #1;
            chk($sformatf("t2_exec_ready%0d", i),
                {30'd0, req1_ready, req0_ready}, 0);
            tick(); tick();
        end
        chk("t2_resp3", {30'd0, resp1_valid, resp0_valid}, 32'h2);
        chk("t2_data3", resp_data, e1[1]);

        // 3: req1 alone, valid held; one accept every 3 cycles
        req1_valid = 1'b1; req1_a = 32'h5; req1_b = 32'hA; req1_op = 4'h6;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t3_ready%0d", k), 32'(req1_ready), 1);
            chk($sformatf("t3_idle%0d", k), 32'(busy), 0);
            if (k > 0) begin
                chk($sformatf("t3_resp%0d", k), 32'(resp1_valid), 1);
                chk($sformatf("t3_data%0d", k), resp_data, 32'hF);
            end
            tick();
            if (k == 2) req1_valid = 1'b0;
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("t3_exec_ready%0d_%0d", k, j), 32'(req1_ready), 0);
                chk($sformatf("t3_busy%0d_%0d", k, j), 32'(busy), 1);
                tick();
            end
        end
        chk("t3_resp_last", {30'd0, resp1_valid, resp0_valid}, 32'h2);

        // 4: reset during EXEC drops the operation and restores prio=0
        req0_valid = 1'b1; req0_a = 32'h1234; req0_b = 32'h4321; req0_op = 4'h5;
        #1;
        chk("t4_ready", 32'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t4_busy", 32'(busy), 0);
        chk("t4_alu_a", alu_a, 0);
        chk("t4_alu_b", alu_b, 0);
        chk("t4_alu_op", 32'(alu_op), 0);
        chk("t4_resp_a", {30'd0, resp1_valid, resp0_valid}, 0);
        tick();
        chk("t4_resp_b", {30'd0, resp1_valid, resp0_valid}, 0);
        tick();
        chk("t4_resp_c", {30'd0, resp1_valid, resp0_valid}, 0);

        // 5: tie goes to req0; only the final-cycle result is captured
        use_stub = 1'b1; stub_val = 32'h9999_0000;
        req0_valid = 1'b1; req0_a = 32'h11; req0_b = 32'h22; req0_op = 4'hC;
        req1_valid = 1'b1; req1_a = 32'h300; req1_b = 32'h0; req1_op = 4'h1;
        #1;
        chk("t4_tie", {30'd0, req1_ready, req0_ready}, 32'h1);
        tick();
        req0_valid = 1'b0;
        stub_val = 32'hAAAA_0001;
        chk("t5_alu_a0", alu_a, 32'h11);
        chk("t5_alu_op0", 32'(alu_op), 32'hC);
        tick();
        stub_val = 32'hBBBB_0002;
        chk("t5_alu_a1", alu_a, 32'h11);
        chk("t5_alu_b1", alu_b, 32'h22);
        chk("t5_alu_op1", 32'(alu_op), 32'hC);
        tick();
        chk("t5_resp", {30'd0, resp1_valid, resp0_valid}, 32'h1);
        chk("t5_data", resp_data, 32'hBBBB_0002);
        chk("t5_alu_keep", alu_a, 32'h11);
        chk("t5_same_cycle_ready", 32'(req1_ready), 1);
        use_stub = 1'b0;
        tick();
        req1_valid = 1'b0;
        tick(); tick();
        chk("t5_resp1", {30'd0, resp1_valid, resp0_valid}, 32'h2);
        chk("t5_data1", resp_data, 32'h300);

        // 6: EXEC_CYCLES=1, accepts every 2 cycles under load
        q0_valid = 1'b1; q1_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_ready%0d", i), {30'd0, q1_ready, q0_ready},
                (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i > 0) begin
                chk($sformatf("t6_resp%0d", i - 1), {30'd0, x_resp1, x_resp0},
                    (i % 2 == 1) ? 32'h1 : 32'h2);
                chk($sformatf("t6_data%0d", i - 1), x_data, xe[(i-1) % 2]);
            end
            tick();
            chk($sformatf("t6_busy%0d", i), 32'(x_busy), 1);
            chk($sformatf("t6_exec_ready%0d", i), {30'd0, q1_ready, q0_ready}, 0);
            tick();
        end
        chk("t6_resp3", {30'd0, x_resp1, x_resp0}, 32'h2);
        chk("t6_data3", x_data, xe[1]);
        q0_valid = 1'b0; q1_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
